shift_seq_unit: RTL and testbench

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_stage.sv | 39 +++
 rtl/shift_seq_unit.sv | 105 ++++++++++
 tb/tb_shift_seq_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // One stage per bit of the shift count.
  localparam int SHIFT_STAGES = 4;

endpackage

// File: rtl/shift_stage.sv
// One conditional stage of the log shifter: moves value by 2^stage when enabled.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STG_W = 2
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  input  logic             enable,
  input  logic [STG_W-1:0] stage,
  output logic [WIDTH-1:0] result
);

  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic [AMT_W-1:0] amt;
  logic [AMT_W-1:0] back;

  // back is the complementary distance used to wrap bits for rotates.
  always_comb begin
    amt  = AMT_W'(1) << stage;
    back = AMT_W'(WIDTH) - amt;
  end

  always_comb begin
    result = value;
    if (enable) begin
      case (op)
        OP_ROL:  result = (value << amt) | (value >> back);
        OP_SLL:  result = value << amt;
        OP_ROR:  result = (value >> amt) | (value << back);
        OP_SRL:  result = value >> amt;
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential barrel shifter: one log-shift stage per cycle, valid/ready on both sides.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero
);

  localparam int STG_W = $clog2(CNT_W);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(CNT_W - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] stage_val;
  logic             accept;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Out       = val_q;
  assign Zero      = out_valid & (val_q == '0);
  assign accept    = in_valid & in_ready & ~flush;

  shift_stage #(
    .WIDTH (WIDTH),
    .STG_W (STG_W)
  ) u_stage (
    .value  (val_q),
    .op     (op_q),
    .enable (cnt_q[stage_q]),
    .stage  (stage_q),
    .result (stage_val)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    stage_d = stage_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_e'(Op);
          cnt_d   = Cnt;
          val_d   = In;
          stage_d = '0;
          state_d = (Cnt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        val_d   = stage_val;
        stage_d = stage_q + STG_W'(1);
        if (stage_q == LAST_STAGE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over both the input accept and the output handshake.
    if (flush) begin
      state_d = ST_IDLE;
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ROL;
      cnt_q   <= '0;
      val_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: vector table plus stall, flush and reset sequences.
module tb_shift_seq_unit;
  import shift_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] exp_out;
    logic        exp_zero;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  Op;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        Zero;

  int vec_count;
  int miscompares;

  vec_t vecs[14];

  shift_seq_unit #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Op        (Op),
    .In        (In),
    .Cnt       (Cnt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one request for a single edge, then scramble the operand inputs.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] din, input logic [3:0] cnt);
    Op       = op;
    In       = din;
    Cnt      = cnt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    Op       = ~op;
    In       = ~din;
    Cnt      = ~cnt;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    while (!out_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int edges;
    checkOutput({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    applyStimulus(v.op, v.din, v.cnt);
    waitDone(edges);
    // Edges counted after the accepting edge; a zero count finishes on the accept itself.
    checkOutput({tag, " latency"}, 32'(edges), (v.cnt == 4'd0) ? 32'd0 : 32'd4);
    checkOutput({tag, " Out"}, 32'(Out), 32'(v.exp_out));
    checkOutput({tag, " Zero"}, 32'(Zero), 32'(v.exp_zero));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   edges;
    logic seen;
    logic [15:0] held;

    vec_count   = 0;
    miscompares = 0;

    vecs[0]  = '{OP_SRL, 16'h8001, 4'd15, 16'h0001, 1'b0};
    vecs[1]  = '{OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b0};
    vecs[2]  = '{OP_ROR, 16'h0001, 4'd4,  16'h1000, 1'b0};
    vecs[3]  = '{OP_SLL, 16'h00FF, 4'd8,  16'hFF00, 1'b0};
    vecs[4]  = '{OP_SRL, 16'h0001, 4'd0,  16'h0001, 1'b0};
    vecs[5]  = '{OP_SRL, 16'h0001, 4'd1,  16'h0000, 1'b1};
    vecs[6]  = '{OP_ROL, 16'h1234, 4'd4,  16'h2341, 1'b0};
    vecs[7]  = '{OP_ROR, 16'h1234, 4'd8,  16'h3412, 1'b0};
    vecs[8]  = '{OP_SLL, 16'hFFFF, 4'd15, 16'h8000, 1'b0};
    vecs[9]  = '{OP_ROL, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    vecs[10] = '{OP_ROR, 16'h8001, 4'd15, 16'h0003, 1'b0};
    vecs[11] = '{OP_SLL, 16'h0001, 4'd3,  16'h0008, 1'b0};
    vecs[12] = '{OP_ROL, 16'h0F0F, 4'd12, 16'hF0F0, 1'b0};
    vecs[13] = '{OP_SRL, 16'hF000, 4'd13, 16'h0007, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    Op        = 2'b00;
    In        = 16'h0;
    Cnt       = 4'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset values are observed before the first clock edge.
    #3;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset Out", 32'(Out), 32'd0);
    checkOutput("reset Zero", 32'(Zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Output stall: result held while downstream is not ready.
    applyStimulus(OP_SLL, 16'h00FF, 4'd8);
    waitDone(edges);
    checkOutput("stall latency", 32'(edges), 32'd4);
    held = Out;
    checkOutput("stall Out", 32'(held), 32'hFF00);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d Out", c), 32'(Out), 32'hFF00);
      checkOutput($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d Zero", c), 32'(Zero), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("stall release in_ready", 32'(in_ready), 32'd1);
    checkOutput("stall release out_valid", 32'(out_valid), 32'd0);

    // Flush during the second shift cycle.
    applyStimulus(OP_ROL, 16'h1234, 4'd15);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush no out_valid", 32'(seen), 32'd0);

    // Flush beats a simultaneous accept.
    Op = OP_SRL; In = 16'h0001; Cnt = 4'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush vs accept in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush vs accept out_valid", 32'(out_valid), 32'd0);
    runVector(vecs[6], "post_flush");

    // Flush beats the output handshake while stalled in DONE.
    applyStimulus(OP_SRL, 16'h0001, 4'd0);
    checkOutput("done flush pre out_valid", 32'(out_valid), 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    checkOutput("done flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("done flush in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of shifting.
    applyStimulus(OP_SLL, 16'h00FF, 4'd8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid reset Out", 32'(Out), 32'd0);
    checkOutput("mid reset Zero", 32'(Zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("mid reset no stale result", 32'(seen), 32'd0);
    runVector(vecs[2], "post_reset");

    // New request accepted on the very first edge after reset release.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    runVector(vecs[1], "first_edge");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
